// File: rtl/btb_update_ctrl_if.sv
// btb_update_ctrl_if: requester handshakes, flush control and BTB write/clear ports
interface btb_update_ctrl_if #(parameter int XLEN = 32, parameter int IDX_LEN = 5);
  logic bru_req_i;
  logic bru_ready_o;
  logic [XLEN-1:0] bru_pc_i;
  logic [XLEN-1:0] bru_tgt_i;
  logic [2:0] bru_type_i;
  logic idu_req_i;
  logic idu_ready_o;
  logic [XLEN-1:0] idu_pc_i;
  logic [XLEN-1:0] idu_tgt_i;
  logic [2:0] idu_type_i;
  logic flush_req_i;
  logic flush_busy_o;
  logic flush_done_o;
  logic btb_wr_req_o;
  logic [XLEN-1:0] btb_wr_pc_o;
  logic [XLEN-1:0] btb_wr_predictedpc_o;
  logic [2:0] btb_wr_branchtype_o;
  logic btb_clr_req_o;
  logic [IDX_LEN-1:0] btb_clr_index_o;
  modport slave(
    input bru_req_i, bru_pc_i, bru_tgt_i, bru_type_i,
    input idu_req_i, idu_pc_i, idu_tgt_i, idu_type_i, flush_req_i,
    output bru_ready_o, idu_ready_o, flush_busy_o, flush_done_o,
    output btb_wr_req_o, btb_wr_pc_o, btb_wr_predictedpc_o, btb_wr_branchtype_o,
    output btb_clr_req_o, btb_clr_index_o
  );
  modport master(
    output bru_req_i, bru_pc_i, bru_tgt_i, bru_type_i,
    output idu_req_i, idu_pc_i, idu_tgt_i, idu_type_i, flush_req_i,
    input bru_ready_o, idu_ready_o, flush_busy_o, flush_done_o,
    input btb_wr_req_o, btb_wr_pc_o, btb_wr_predictedpc_o, btb_wr_branchtype_o,
    input btb_clr_req_o, btb_clr_index_o
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: arbitrates BRU/IDU BTB updates through a coalescing queue and walks the BTB clear on flush
module btb_update_ctrl #(
  parameter int BTB_SIZE = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int XLEN = 32
) (
  input logic clk_i,
  input logic rst_ni,
  btb_update_ctrl_if.slave bus
);
  localparam int IDX_LEN = $clog2(BTB_SIZE);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
  state_t r_state;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_head, r_tail;
  logic [IDX_LEN-1:0] r_walk;
  logic [XLEN-1:0] r_pc [QUEUE_DEPTH];
  logic [XLEN-1:0] r_tgt [QUEUE_DEPTH];
  logic [2:0] r_type [QUEUE_DEPTH];
  logic w_run, w_pop, w_bru_acc, w_idu_acc, w_bru_hit, w_idu_hit, w_idu_drop, w_bru_push, w_idu_push;
  logic [PW-1:0] w_bru_hidx, w_idu_hidx, w_bru_idx, w_idu_idx;
  logic [CW-1:0] w_count_nxt;
  assign w_run = rst_ni && r_state == RUN && !bus.flush_req_i;
  assign w_pop = w_run && r_count != '0;
  assign bus.bru_ready_o = w_run && r_count < CW'(QUEUE_DEPTH);
  assign bus.idu_ready_o = w_run && (r_count + CW'(bus.bru_req_i)) < CW'(QUEUE_DEPTH);
  assign w_bru_acc = bus.bru_req_i && bus.bru_ready_o;
  assign w_idu_acc = bus.idu_req_i && bus.idu_ready_o;
  // the entry being popped this cycle is not a coalesce target
  always_comb begin
    w_bru_hit = 1'b0;
    w_idu_hit = 1'b0;
    w_bru_hidx = '0;
    w_idu_hidx = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++)
      if ({1'b0, PW'(i) - r_head} < r_count && !(w_pop && PW'(i) == r_head)) begin
        if (r_pc[i] == bus.bru_pc_i) begin
          w_bru_hit = 1'b1;
          w_bru_hidx = PW'(i);
        end
        if (r_pc[i] == bus.idu_pc_i) begin
          w_idu_hit = 1'b1;
          w_idu_hidx = PW'(i);
        end
      end
  end
  assign w_idu_drop = w_bru_acc && bus.bru_pc_i == bus.idu_pc_i;
  assign w_bru_push = w_bru_acc && !w_bru_hit;
  assign w_idu_push = w_idu_acc && !w_idu_hit && !w_idu_drop;
  assign w_bru_idx = w_bru_hit ? w_bru_hidx : r_tail;
  assign w_idu_idx = w_idu_hit ? w_idu_hidx : r_tail + PW'(w_bru_push);
  assign w_count_nxt = r_count + CW'(w_bru_push) + CW'(w_idu_push) - CW'(w_pop);
  always_ff @(posedge clk_i) begin
    if (w_idu_acc && !w_idu_drop) begin
      r_pc[w_idu_idx] <= bus.idu_pc_i;
      r_tgt[w_idu_idx] <= bus.idu_tgt_i;
      r_type[w_idu_idx] <= bus.idu_type_i;
    end
    if (w_bru_acc) begin
      r_pc[w_bru_idx] <= bus.bru_pc_i;
      r_tgt[w_bru_idx] <= bus.bru_tgt_i;
      r_type[w_bru_idx] <= bus.bru_type_i;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= RUN;
      r_count <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_walk <= '0;
    end else begin
      case (r_state)
        RUN: if (bus.flush_req_i) begin
          r_state <= FLUSH;
          r_count <= '0;
          r_head <= '0;
          r_tail <= '0;
        end else begin
          r_count <= w_count_nxt;
          r_head <= r_head + PW'(w_pop);
          r_tail <= r_tail + PW'(w_bru_push) + PW'(w_idu_push);
        end
        FLUSH: begin
          r_walk <= r_walk + 1'b1;
          if (r_walk == IDX_LEN'(BTB_SIZE - 1)) r_state <= DONE;
        end
        default: r_state <= RUN;
      endcase
    end
  end
  assign bus.btb_wr_req_o = w_pop;
  assign bus.btb_wr_pc_o = w_pop ? r_pc[r_head] : '0;
  assign bus.btb_wr_predictedpc_o = w_pop ? r_tgt[r_head] : '0;
  assign bus.btb_wr_branchtype_o = w_pop ? r_type[r_head] : '0;
  assign bus.flush_busy_o = r_state == FLUSH;
  assign bus.flush_done_o = r_state == DONE;
  assign bus.btb_clr_req_o = r_state == FLUSH;
  assign bus.btb_clr_index_o = r_state == FLUSH ? r_walk : '0;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: directed stimulus checked every cycle against a queue-based model of the update controller
module tb_btb_update_ctrl;
  typedef struct {logic [31:0] pc; logic [31:0] tgt; logic [2:0] ty;} ent_t;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int n_cmp = 0, n_bad = 0;
  ent_t q[$];
  ent_t wr_log[$];
  int clr_log[$];
  int ph = 0, widx = 0, n_done = 0;
  logic [31:0] exp3 [6] = '{32'h400, 32'h404, 32'h408, 32'h40c, 32'h410, 32'h414};
  btb_update_ctrl_if #(.XLEN(32), .IDX_LEN(5)) bus();
  btb_update_ctrl #(.BTB_SIZE(32), .QUEUE_DEPTH(4), .XLEN(32)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus.slave));
  always #5 clk_i = ~clk_i;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    ph = 0;
    widx = 0;
  endtask
  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] ty);
    ent_t e;
    for (int j = 0; j < q.size(); j++)
      if (q[j].pc == pc) begin
        e = q[j];
        e.tgt = tgt;
        e.ty = ty;
        q[j] = e;
        return;
      end
    e.pc = pc;
    e.tgt = tgt;
    e.ty = ty;
    q.push_back(e);
  endtask
  task automatic model_step();
    logic ba, ia;
    if (!rst_ni) return;
    if (ph == 0) begin
      if (bus.flush_req_i) begin
        q.delete();
        ph = 1;
        widx = 0;
      end else begin
        ba = bus.bru_req_i && q.size() < 4;
        ia = bus.idu_req_i && q.size() + int'(bus.bru_req_i) < 4;
        if (q.size() > 0) void'(q.pop_front());
        if (ba) upd(bus.bru_pc_i, bus.bru_tgt_i, bus.bru_type_i);
        if (ia && !(ba && bus.idu_pc_i == bus.bru_pc_i)) upd(bus.idu_pc_i, bus.idu_tgt_i, bus.idu_type_i);
      end
    end else if (ph == 1) begin
      widx++;
      if (widx == 32) begin
        ph = 2;
        widx = 0;
      end
    end else ph = 0;
  endtask
  task automatic compare_all();
    logic run, wr, clr;
    ent_t h;
    run = rst_ni && ph == 0 && !bus.flush_req_i;
    wr = run && q.size() > 0;
    clr = rst_ni && ph == 1;
    h.pc = 0;
    h.tgt = 0;
    h.ty = 0;
    if (wr) h = q[0];
    chk("bru_ready", bus.bru_ready_o, run && q.size() < 4);
    chk("idu_ready", bus.idu_ready_o, run && q.size() + int'(bus.bru_req_i) < 4);
    chk("wr_req", bus.btb_wr_req_o, wr);
    chk("wr_pc", bus.btb_wr_pc_o, h.pc);
    chk("wr_tgt", bus.btb_wr_predictedpc_o, h.tgt);
    chk("wr_type", bus.btb_wr_branchtype_o, h.ty);
    chk("clr_req", bus.btb_clr_req_o, clr);
    chk("clr_index", bus.btb_clr_index_o, clr ? widx : 0);
    chk("flush_busy", bus.flush_busy_o, clr);
    chk("flush_done", bus.flush_done_o, rst_ni && ph == 2);
    if (bus.btb_wr_req_o) wr_log.push_back('{bus.btb_wr_pc_o, bus.btb_wr_predictedpc_o, bus.btb_wr_branchtype_o});
    if (bus.btb_clr_req_o) clr_log.push_back(int'(bus.btb_clr_index_o));
    if (bus.flush_done_o) n_done++;
  endtask
  task automatic tick();
    @(negedge clk_i);
    compare_all();
    @(posedge clk_i);
    model_step();
    #1;
  endtask
  task automatic drive(input logic br, input logic [31:0] bp, input logic [31:0] bt, input logic [2:0] bty,
                       input logic ir, input logic [31:0] ip, input logic [31:0] it, input logic [2:0] ity);
    bus.bru_req_i = br;
    bus.bru_pc_i = bp;
    bus.bru_tgt_i = bt;
    bus.bru_type_i = bty;
    bus.idu_req_i = ir;
    bus.idu_pc_i = ip;
    bus.idu_tgt_i = it;
    bus.idu_type_i = ity;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    bus.flush_req_i = 1'b0;
    model_reset();
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
    chk("rst_bru_ready", bus.bru_ready_o, 1);
    chk("rst_idu_ready", bus.idu_ready_o, 1);
    chk("rst_wr_req", bus.btb_wr_req_o, 0);
    tick();
    // single BRU update
    wr_log.delete();
    drive(1, 32'h8000_0010, 32'h8000_0100, 3, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("t1_writes", wr_log.size(), 1);
    chk("t1_pc", wr_log[0].pc, 32'h8000_0010);
    chk("t1_tgt", wr_log[0].tgt, 32'h8000_0100);
    chk("t1_type", wr_log[0].ty, 3);
    // both requesters in one cycle
    wr_log.delete();
    drive(1, 32'h100, 32'h1000, 1, 1, 32'h200, 32'h2000, 2);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("t2_writes", wr_log.size(), 2);
    chk("t2_first", wr_log[0].pc, 32'h100);
    chk("t2_second", wr_log[1].pc, 32'h200);
    chk("t2_second_tgt", wr_log[1].tgt, 32'h2000);
    // fill towards full; IDU must hold when only BRU fits
    wr_log.delete();
    drive(1, 32'h400, 32'h4000, 1, 1, 32'h404, 32'h4040, 2);
    tick();
    drive(1, 32'h408, 32'h4080, 3, 1, 32'h40c, 32'h40c0, 4);
    tick();
    drive(1, 32'h410, 32'h4100, 5, 1, 32'h414, 32'h4140, 6);
    #1;
    chk("t3_idu_ready_cnt3", bus.idu_ready_o, 0);
    chk("t3_bru_ready_cnt3", bus.bru_ready_o, 1);
    tick();
    drive(0, 0, 0, 0, 1, 32'h414, 32'h4140, 6);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) tick();
    chk("t3_writes", wr_log.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_order%0d", i), wr_log[i].pc, exp3[i]);
    // coalesce into a queued, non-head entry
    wr_log.delete();
    drive(1, 32'h500, 32'h55, 1, 1, 32'h300, 32'hA, 2);
    tick();
    drive(1, 32'h300, 32'hB, 4, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("t4_writes", wr_log.size(), 2);
    chk("t4_pc", wr_log[1].pc, 32'h300);
    chk("t4_tgt", wr_log[1].tgt, 32'hB);
    chk("t4_type", wr_log[1].ty, 4);
    // same PC from both requesters: BRU data wins
    wr_log.delete();
    drive(1, 32'h600, 32'h66, 5, 1, 32'h600, 32'h77, 6);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("t4b_writes", wr_log.size(), 1);
    chk("t4b_tgt", wr_log[0].tgt, 32'h66);
    // flush with two queued entries
    drive(1, 32'h700, 32'h77, 1, 1, 32'h704, 32'h74, 2);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    wr_log.delete();
    clr_log.delete();
    n_done = 0;
    bus.flush_req_i = 1'b1;
    #1;
    chk("t5_flush_bru_ready", bus.bru_ready_o, 0);
    chk("t5_flush_wr_req", bus.btb_wr_req_o, 0);
    tick();
    bus.flush_req_i = 1'b0;
    repeat (5) tick();
    bus.flush_req_i = 1'b1;
    tick();
    bus.flush_req_i = 1'b0;
    repeat (27) tick();
    chk("t5_writes", wr_log.size(), 0);
    chk("t5_clears", clr_log.size(), 32);
    for (int i = 0; i < 32; i++) chk($sformatf("t5_idx%0d", i), clr_log[i], i);
    chk("t5_done_pulses", n_done, 1);
    chk("t5_bru_ready_after", bus.bru_ready_o, 1);
    chk("t5_idu_ready_after", bus.idu_ready_o, 1);
    tick();
    // reset in the middle of the walk
    bus.flush_req_i = 1'b1;
    tick();
    bus.flush_req_i = 1'b0;
    repeat (10) tick();
    chk("t6_idx_before_rst", bus.btb_clr_index_o, 10);
    rst_ni = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_clr_req", bus.btb_clr_req_o, 0);
    chk("t6_rst_busy", bus.flush_busy_o, 0);
    chk("t6_rst_bru_ready", bus.bru_ready_o, 0);
    chk("t6_rst_clr_index", bus.btb_clr_index_o, 0);
    tick();
    tick();
    rst_ni = 1'b1;
    clr_log.delete();
    repeat (3) tick();
    chk("t6_no_clears", clr_log.size(), 0);
    chk("t6_bru_ready", bus.bru_ready_o, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
